// File: rtl/dma_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_csr_pkg
// Description : Shared definitions for the DMA control/status CSR bank:
//               CSR addresses, CTRL/STATUS bit positions, run-state enum
//               and a saturating 16-bit increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_csr_pkg;

    // CSR addresses
    localparam logic [7:0] DMA_LAYER  = 8'h50;
    localparam logic [7:0] DMA_CTRL   = 8'h51;
    localparam logic [7:0] DMA_COUNT  = 8'h52;
    localparam logic [7:0] DMA_STATUS = 8'h53;
    localparam logic [7:0] DMA_BURST  = 8'h54;

    // CTRL bit positions
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_ABORT_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_AUTO_INC_BIT = 3;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_ERR_BIT     = 2;
    localparam int STAT_ABORTED_BIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2
    } dma_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_run_ctl.sv
`default_nettype none
// ============================================================================
// Module      : dma_run_ctl
// Description : DMA run sequencer. Tracks IDLE/RUN/ABORT, counts completed
//               bursts, issues registered start/abort pulses to the engine
//               and produces same-cycle set strobes for the sticky
//               DONE/ERR/ABORTED status bits held by the register bank.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_start_req/i_abort_req - software START/ABORT write strobes
//               i_count, i_burst_len    - configured bursts / beats per burst
//               i_burst_done, i_error, i_idle - engine events and status
//               o_state, o_bursts_done  - run state and completed bursts
//               o_dma_start, o_dma_abort - one-cycle engine pulses
//               o_set_done/err/aborted  - sticky-bit set strobes
// Revision    : 1.0 - initial release
// ============================================================================
module dma_run_ctl
    import dma_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start_req,
    input  logic        i_abort_req,
    input  logic [15:0] i_count,
    input  logic [7:0]  i_burst_len,
    input  logic        i_burst_done,
    input  logic        i_error,
    input  logic        i_idle,
    output dma_state_e  o_state,
    output logic [15:0] o_bursts_done,
    output logic        o_dma_start,
    output logic        o_dma_abort,
    output logic        o_set_done,
    output logic        o_set_err,
    output logic        o_set_aborted
);

    dma_state_e  r_state;
    logic [15:0] r_bursts;
    logic        r_dma_start;
    logic        r_dma_abort;

    logic        w_cfg_ok;
    logic [15:0] w_bursts_inc;
    logic        w_last_burst;

    assign w_cfg_ok     = (i_count != 16'd0) && (i_burst_len != 8'd0);
    assign w_bursts_inc = sat_inc16(r_bursts);
    assign w_last_burst = i_burst_done && (w_bursts_inc == i_count);

    // Engine errors are flagged in RUN and ABORT; an error beats completion.
    always_comb begin
        o_set_done    = (r_state == RUN) && w_last_burst && !i_error;
        o_set_err     = ((r_state == IDLE) && i_start_req && !w_cfg_ok) ||
                        ((r_state != IDLE) && i_error);
        o_set_aborted = (r_state == ABORT) && i_idle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bursts    <= 16'd0;
            r_dma_start <= 1'b0;
            r_dma_abort <= 1'b0;
        end else begin
            r_dma_start <= 1'b0;
            r_dma_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start_req && w_cfg_ok) begin
                        r_state     <= RUN;
                        r_bursts    <= 16'd0;
                        r_dma_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_burst_done) r_bursts <= w_bursts_inc;
                    if (i_error || w_last_burst) begin
                        r_state <= IDLE;
                    end else if (i_abort_req) begin
                        r_state     <= ABORT;
                        r_dma_abort <= 1'b1;
                    end
                end
                ABORT: begin
                    // Late bursts still count; only engine quiescence exits.
                    if (i_burst_done) r_bursts <= w_bursts_inc;
                    if (i_idle) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_bursts_done = r_bursts;
    assign o_dma_start   = r_dma_start;
    assign o_dma_abort   = r_dma_abort;

endmodule
`default_nettype wire

// File: rtl/dma_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : dma_csr_bank
// Description : DMA control/status CSR bank at 0x50-0x54. Holds LAYER, CTRL,
//               COUNT, STATUS and BURST, applies W1C to the sticky status
//               bits, returns combinational read data and drives the DMA
//               engine configuration through the dma_run_ctl sequencer.
// Ports       : clk, rst - clock, synchronous active-high reset
//               csr_addr/csr_wen/csr_ren/csr_wdata/csr_rdata - CSR access
//               dma_start, dma_abort - engine command pulses
//               dma_layer, dma_count, dma_burst_len - engine configuration
//               dma_burst_done, dma_error, dma_idle - engine events
//               dma_irq - level interrupt (only with DMA_CSR_IRQ_EN)
// Config      : `define DMA_CSR_IRQ_EN to build IRQ_EN and the dma_irq port.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_csr_bank
    import dma_csr_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    input  logic                      csr_wen,
    input  logic                      csr_ren,
    input  logic [CSR_DATA_WIDTH-1:0] csr_wdata,
    output logic [CSR_DATA_WIDTH-1:0] csr_rdata,
    output logic                      dma_start,
    output logic                      dma_abort,
    output logic [7:0]                dma_layer,
    output logic [15:0]               dma_count,
    output logic [7:0]                dma_burst_len,
`ifdef DMA_CSR_IRQ_EN
    output logic                      dma_irq,
`endif
    input  logic                      dma_burst_done,
    input  logic                      dma_error,
    input  logic                      dma_idle
);

    logic [7:0]  r_layer;
    logic        r_auto_inc;
    logic [15:0] r_count;
    logic [7:0]  r_burst;
    logic        r_done;
    logic        r_err;
    logic        r_aborted;
    logic        w_irq_en;

    dma_state_e  w_state;
    logic [15:0] w_bursts_done;
    logic        w_set_done;
    logic        w_set_err;
    logic        w_set_aborted;
    logic        w_busy;

    logic w_wr_layer, w_wr_ctrl, w_wr_count, w_wr_status, w_wr_burst;
    logic w_start_req, w_abort_req;

    assign w_wr_layer  = csr_wen && (csr_addr == CSR_ADDR_WIDTH'(DMA_LAYER));
    assign w_wr_ctrl   = csr_wen && (csr_addr == CSR_ADDR_WIDTH'(DMA_CTRL));
    assign w_wr_count  = csr_wen && (csr_addr == CSR_ADDR_WIDTH'(DMA_COUNT));
    assign w_wr_status = csr_wen && (csr_addr == CSR_ADDR_WIDTH'(DMA_STATUS));
    assign w_wr_burst  = csr_wen && (csr_addr == CSR_ADDR_WIDTH'(DMA_BURST));
    assign w_start_req = w_wr_ctrl && csr_wdata[CTRL_START_BIT];
    assign w_abort_req = w_wr_ctrl && csr_wdata[CTRL_ABORT_BIT];
    assign w_busy      = (w_state != IDLE);

    dma_run_ctl u_run_ctl (
        .clk           (clk),
        .rst           (rst),
        .i_start_req   (w_start_req),
        .i_abort_req   (w_abort_req),
        .i_count       (r_count),
        .i_burst_len   (r_burst),
        .i_burst_done  (dma_burst_done),
        .i_error       (dma_error),
        .i_idle        (dma_idle),
        .o_state       (w_state),
        .o_bursts_done (w_bursts_done),
        .o_dma_start   (dma_start),
        .o_dma_abort   (dma_abort),
        .o_set_done    (w_set_done),
        .o_set_err     (w_set_err),
        .o_set_aborted (w_set_aborted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer    <= 8'd0;
            r_auto_inc <= 1'b0;
            r_count    <= 16'd0;
            r_burst    <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            // Software write to LAYER takes precedence over auto-increment.
            if (w_wr_layer)
                r_layer <= csr_wdata[7:0];
            else if (w_set_done && r_auto_inc)
                r_layer <= r_layer + 8'd1;

            if (w_wr_ctrl)              r_auto_inc <= csr_wdata[CTRL_AUTO_INC_BIT];
            if (w_wr_count && !w_busy)  r_count    <= csr_wdata[15:0];
            if (w_wr_burst && !w_busy)  r_burst    <= csr_wdata[7:0];

            // Hardware set wins over a simultaneous W1C.
            r_done    <= w_set_done    ||
                         (r_done    && !(w_wr_status && csr_wdata[STAT_DONE_BIT]));
            r_err     <= w_set_err     ||
                         (r_err     && !(w_wr_status && csr_wdata[STAT_ERR_BIT]));
            r_aborted <= w_set_aborted ||
                         (r_aborted && !(w_wr_status && csr_wdata[STAT_ABORTED_BIT]));
        end
    end

`ifdef DMA_CSR_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= csr_wdata[CTRL_IRQ_EN_BIT];
            r_irq <= r_irq_en && (r_done || r_err || r_aborted);
        end
    end

    assign w_irq_en = r_irq_en;
    assign dma_irq  = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = 32'd0;
        case (csr_addr)
            CSR_ADDR_WIDTH'(DMA_LAYER):  w_rdata = {24'd0, r_layer};
            CSR_ADDR_WIDTH'(DMA_CTRL):   w_rdata = {28'd0, r_auto_inc, w_irq_en, 2'b00};
            CSR_ADDR_WIDTH'(DMA_COUNT):  w_rdata = {16'd0, r_count};
            CSR_ADDR_WIDTH'(DMA_STATUS): w_rdata = {w_bursts_done, 12'd0,
                                                    r_aborted, r_err, r_done, w_busy};
            CSR_ADDR_WIDTH'(DMA_BURST):  w_rdata = {24'd0, r_burst};
            default:                     w_rdata = 32'd0;
        endcase
    end

    assign csr_rdata = CSR_DATA_WIDTH'(w_rdata);

    assign dma_layer     = r_layer;
    assign dma_count     = r_count;
    assign dma_burst_len = r_burst;

    // Reads are side-effect free, so the read strobe and upper write bits
    // carry no information for this bank.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, csr_ren, csr_wdata[CSR_DATA_WIDTH-1:16]};

endmodule
`default_nettype wire
